// File: rtl/shift_stage.sv
// shift_stage: two-register shift execution stage in front of writeback.
// S1 holds the issued operation; S2 holds the shifted result, tag and
// illegal flag. Right shifts reuse the left shifter through bit reversal.
// Optional feature macro: SHIFT_STAGE_ROTATE_EN enables ROL on op 3.
// Without it, op 3 returns 0 and sets out_illegal.
module shift_stage #(
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [31:0]          in_value,
    input  logic [4:0]           in_amount,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_illegal
);

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;

    // S1 registers (operation as issued)
    logic                 s1_valid_q, s1_valid_d;
    logic [1:0]           s1_op_q;
    logic [31:0]          s1_value_q;
    logic [4:0]           s1_amount_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;

    // S2 registers (result as offered to writeback)
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_result_q, s2_result_d;
    logic [TAG_WIDTH-1:0] s2_tag_q;
    logic                 s2_illegal_q, s2_illegal_d;

    logic s1_adv, s2_adv, s1_load, s2_load;

    function automatic logic [31:0] bit_reverse(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Left shift; vacated low bits take the fill value.
    function automatic logic [31:0] shift_left_fill(input logic [31:0] v,
                                                    input logic [4:0]  amt,
                                                    input logic        fill);
        logic [31:0] fill_mask;
        fill_mask = fill ? ~(32'hFFFF_FFFF << amt) : 32'h0;
        return (v << amt) | fill_mask;
    endfunction

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !flush;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s2_adv && s1_valid_q;

    // Valid-bit next state: flush squashes both stages, stalls hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_adv) s1_valid_d = in_valid;
            if (s2_adv) s2_valid_d = s1_valid_q;
        end
    end

    // Shifter datapath between S1 and S2.
    always_comb begin
        s2_result_d  = 32'h0;
        s2_illegal_d = 1'b0;
        case (s1_op_q)
            OP_SLL: s2_result_d = shift_left_fill(s1_value_q, s1_amount_q, 1'b0);
            OP_SRL: s2_result_d = bit_reverse(shift_left_fill(bit_reverse(s1_value_q),
                                                              s1_amount_q, 1'b0));
            OP_SRA: s2_result_d = bit_reverse(shift_left_fill(bit_reverse(s1_value_q),
                                                              s1_amount_q, s1_value_q[31]));
            default: begin
`ifdef SHIFT_STAGE_ROTATE_EN
                if (s1_amount_q == 5'd0) begin
                    s2_result_d = s1_value_q;
                end else begin
                    s2_result_d = (s1_value_q << s1_amount_q) |
                                  (s1_value_q >> (6'd32 - {1'b0, s1_amount_q}));
                end
`else
                s2_result_d  = 32'h0;
                s2_illegal_d = 1'b1;
`endif
            end
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // S1 operand capture; only meaningful while s1_valid_q is set.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_op_q     <= in_op;
            s1_value_q  <= in_value;
            s1_amount_q <= in_amount;
            s1_tag_q    <= in_tag;
        end
    end

    // S2 result capture; reset clears the visible outputs immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_result_q  <= 32'h0;
            s2_tag_q     <= '0;
            s2_illegal_q <= 1'b0;
        end else if (s2_load) begin
            s2_result_q  <= s2_result_d;
            s2_tag_q     <= s1_tag_q;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_tag     = s2_tag_q;
    assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_shift_stage.sv
// Directed bench for shift_stage (default build unless SHIFT_STAGE_ROTATE_EN).
module tb_shift_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_value;
    logic [4:0]  in_amount;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    shift_stage #(.TAG_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_value(in_value), .in_amount(in_amount), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] val,
                         input logic [4:0] amt, input logic [4:0] tag);
        in_valid  = v;
        in_op     = op;
        in_value  = val;
        in_amount = amt;
        in_tag    = tag;
    endtask

    task automatic chk_out(input string name, input logic [31:0] res, input logic [4:0] tag,
                           input logic ill);
        chk({name, "_valid"}, {31'h0, out_valid}, 32'h1);
        chk({name, "_result"}, out_result, res);
        chk({name, "_tag"}, {27'h0, out_tag}, {27'h0, tag});
        chk({name, "_illegal"}, {31'h0, out_illegal}, {31'h0, ill});
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 5'd0, 5'd0);
        #2;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_result", out_result, 32'h0);
        chk("rst_tag", {27'h0, out_tag}, 32'h0);
        chk("rst_illegal", {31'h0, out_illegal}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // SLL 1 by 31, latency two edges
        @(negedge clk);
        drive(1'b1, 2'd0, 32'h0000_0001, 5'd31, 5'd5);
        cyc();
        drive(1'b0, 2'd0, 32'h0, 5'd0, 5'd0);
        chk("sll_lat1_valid", {31'h0, out_valid}, 32'h0);
        cyc();
        chk_out("sll31", 32'h8000_0000, 5'd5, 1'b0);
        cyc();
        chk("sll_drained", {31'h0, out_valid}, 32'h0);

        // Back-to-back SRL / SRA / SRA / SLL / SRA amount 0
        drive(1'b1, 2'd1, 32'h8000_0000, 5'd4, 5'd1);
        cyc();
        drive(1'b1, 2'd2, 32'h8000_0000, 5'd4, 5'd2);
        cyc();
        chk_out("srl4", 32'h0800_0000, 5'd1, 1'b0);
        drive(1'b1, 2'd2, 32'h7FFF_FFFF, 5'd31, 5'd3);
        cyc();
        chk_out("sra4", 32'hF800_0000, 5'd2, 1'b0);
        drive(1'b1, 2'd0, 32'h1234_5678, 5'd4, 5'd4);
        cyc();
        chk_out("sra31_pos", 32'h0000_0000, 5'd3, 1'b0);
        drive(1'b1, 2'd2, 32'h8000_0000, 5'd31, 5'd6);
        cyc();
        chk_out("sll4", 32'h2345_6780, 5'd4, 1'b0);
        drive(1'b1, 2'd2, 32'h8765_4321, 5'd0, 5'd8);
        cyc();
        chk_out("sra31_neg", 32'hFFFF_FFFF, 5'd6, 1'b0);
        drive(1'b0, 2'd0, 32'h0, 5'd0, 5'd0);
        cyc();
        chk_out("sra0", 32'h8765_4321, 5'd8, 1'b0);
        cyc();
        chk("b2b_drained", {31'h0, out_valid}, 32'h0);

        // Backpressure: three ops offered, two accepted
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 32'h3, 5'd1, 5'd10);
        #1;
        chk("bp_rdy_a", {31'h0, in_ready}, 32'h1);
        cyc();
        drive(1'b1, 2'd0, 32'h3, 5'd2, 5'd11);
        #1;
        chk("bp_rdy_b", {31'h0, in_ready}, 32'h1);
        cyc();
        chk_out("bp_hold0", 32'h6, 5'd10, 1'b0);
        drive(1'b1, 2'd0, 32'h3, 5'd3, 5'd12);
        #1;
        chk("bp_rdy_full", {31'h0, in_ready}, 32'h0);
        cyc();
        chk_out("bp_hold1", 32'h6, 5'd10, 1'b0);
        chk("bp_rdy_full2", {31'h0, in_ready}, 32'h0);
        cyc();
        chk_out("bp_hold2", 32'h6, 5'd10, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", {31'h0, in_ready}, 32'h1);
        cyc();
        drive(1'b0, 2'd0, 32'h0, 5'd0, 5'd0);
        chk_out("bp_b", 32'hC, 5'd11, 1'b0);
        cyc();
        chk_out("bp_c", 32'h18, 5'd12, 1'b0);
        cyc();
        chk("bp_drained", {31'h0, out_valid}, 32'h0);

        // Flush with both stages full
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 32'h1, 5'd1, 5'd20);
        cyc();
        drive(1'b1, 2'd0, 32'h1, 5'd2, 5'd21);
        cyc();
        chk_out("fl_full", 32'h2, 5'd20, 1'b0);
        flush = 1'b1;
        drive(1'b1, 2'd0, 32'h1, 5'd3, 5'd22);
        #1;
        chk("fl_in_ready", {31'h0, in_ready}, 32'h0);
        cyc();
        flush = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 5'd0, 5'd0);
        chk("fl_valid0", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b1;
        cyc();
        chk("fl_valid1", {31'h0, out_valid}, 32'h0);
        cyc();
        chk("fl_valid2", {31'h0, out_valid}, 32'h0);

        // Op 3
        drive(1'b1, 2'd3, 32'h8000_0001, 5'd1, 5'd7);
        cyc();
        drive(1'b0, 2'd0, 32'h0, 5'd0, 5'd0);
        cyc();
`ifdef SHIFT_STAGE_ROTATE_EN
        chk_out("rol1", 32'h0000_0003, 5'd7, 1'b0);
`else
        chk_out("op3_illegal", 32'h0000_0000, 5'd7, 1'b1);
`endif
        cyc();

        // Reset while stalled with valid data
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 32'h1, 5'd1, 5'd9);
        cyc();
        drive(1'b0, 2'd0, 32'h0, 5'd0, 5'd0);
        cyc();
        chk_out("stall_pre_rst", 32'h2, 5'd9, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_result", out_result, 32'h0);
        chk("arst_tag", {27'h0, out_tag}, 32'h0);
        chk("arst_illegal", {31'h0, out_illegal}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        chk("post_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
